// File: rtl/dmem_arbiter_vliw_pkg.sv
// Shared types and constants for the VLIW data-memory arbiter.
// Holds the FSM state encoding, default widths, memory depth and lane selectors.
package dmem_arb_pkg;

    // IDLE: accepting new bundles; SECOND: issuing lane 1 of a dual bundle.
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    localparam int DMEM_ADDR_W = 18;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 140001;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_vliw.sv
// Shares one single-port, read-first, 1-cycle-latency data memory between the
// two load/store lanes of a VLIW bundle. Dual bundles are issued lane 0 then
// lane 1 over two cycles with stall raised in the first cycle. Load results
// appear the cycle after the bundle is accepted.
// Optional build macro DMEM_LOAD_MERGE_EN: two loads to the same in-range
// address are served by a single access with no stall.
//
// Handshake: stall=1 means the bundle on req* is not accepted this cycle and
// the pipeline holds req* stable; stall=0 with any valid lane means the bundle
// is accepted (cycle T). rvalidN/oob are one-cycle pulses at T+1; rdataN holds
// its last load value between pulses.
module dmem_arbiter_vliw
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              oob,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              state_dbg
);

    state_t state, state_nxt;

    logic oob0, oob1, merge;
    logic issue, issue_lane, issue_oob;
    logic acc_ld0, acc_ld1, acc_z0, acc_z1, acc_h0, acc_oob, cap_l0;

    // Lane 0 attributes remembered across the stall cycle of a dual bundle.
    logic l0_ld_q, l0_oob_q;
    // Lane 0 load data captured while lane 1 is being issued.
    logic [DATA_W-1:0] hold_q;
    // Result-cycle steering: rvalid, force-zero, and use-hold-register flags.
    logic rv0_q, rv1_q, z0_q, z1_q, h0_q, oob_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign oob0 = req0_addr >= ADDR_W'(DEPTH);
    assign oob1 = req1_addr >= ADDR_W'(DEPTH);

`ifdef DMEM_LOAD_MERGE_EN
    assign merge = req0_valid && req1_valid && !req0_we && !req1_we &&
                   (req0_addr == req1_addr) && !oob0;
`else
    assign merge = 1'b0;
`endif

    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, stall and per-bundle acceptance decode; reset silences all.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        issue      = 1'b0;
        issue_lane = LANE0;
        acc_ld0    = 1'b0;
        acc_ld1    = 1'b0;
        acc_z0     = 1'b0;
        acc_z1     = 1'b0;
        acc_h0     = 1'b0;
        acc_oob    = 1'b0;
        cap_l0     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req0_valid && req1_valid && !merge) begin
                        issue     = 1'b1;
                        stall     = 1'b1;
                        cap_l0    = 1'b1;
                        state_nxt = SECOND;
                    end else if (req0_valid) begin
                        issue   = 1'b1;
                        acc_ld0 = !req0_we;
                        acc_z0  = oob0;
                        acc_oob = oob0;
                        // Merged loads share the single access's data.
                        acc_ld1 = merge;
                    end else if (req1_valid) begin
                        issue      = 1'b1;
                        issue_lane = LANE1;
                        acc_ld1    = !req1_we;
                        acc_z1     = oob1;
                        acc_oob    = oob1;
                    end
                end
                SECOND: begin
                    issue      = req1_valid;
                    issue_lane = LANE1;
                    acc_ld0    = l0_ld_q;
                    acc_h0     = 1'b1;
                    acc_z0     = l0_oob_q;
                    acc_ld1    = req1_valid && !req1_we;
                    acc_z1     = oob1;
                    acc_oob    = l0_oob_q || (req1_valid && oob1);
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Memory port drive from the selected lane; out-of-range accesses are dropped.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_di    = '0;
        issue_oob = (issue_lane == LANE1) ? oob1 : oob0;
        if (issue && !issue_oob) begin
            mem_en = 1'b1;
            if (issue_lane == LANE1) begin
                mem_we   = req1_we;
                mem_addr = req1_addr;
                mem_di   = req1_wdata;
            end else begin
                mem_we   = req0_we;
                mem_addr = req0_addr;
                mem_di   = req0_wdata;
            end
        end
    end

    // Lane 0 attributes latched when a dual bundle starts; its data captured in SECOND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l0_ld_q  <= 1'b0;
            l0_oob_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (cap_l0) begin
                l0_ld_q  <= !req0_we;
                l0_oob_q <= oob0;
            end
            if (state == SECOND) hold_q <= mem_dout;
        end
    end

    // Result-cycle flags registered at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            z0_q  <= 1'b0;
            z1_q  <= 1'b0;
            h0_q  <= 1'b0;
            oob_q <= 1'b0;
        end else begin
            rv0_q <= acc_ld0;
            rv1_q <= acc_ld1;
            z0_q  <= acc_z0;
            z1_q  <= acc_z1;
            h0_q  <= acc_h0;
            oob_q <= acc_oob;
        end
    end

    // Live result on the pulse cycle, otherwise the last delivered value.
    always_comb begin
        rdata0 = rdata0_q;
        rdata1 = rdata1_q;
        if (rv0_q) rdata0 = z0_q ? '0 : (h0_q ? hold_q : mem_dout);
        if (rv1_q) rdata1 = z1_q ? '0 : mem_dout;
    end

    // Keep rdata stable between load results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0;
            rdata1_q <= rdata1;
        end
    end

    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign oob     = oob_q;

endmodule

// File: tb/tb_dmem_arbiter_vliw.sv
// Directed bench for dmem_arbiter_vliw with a read-first RAM model and a
// scoreboard of expected per-lane load results and oob pulses.
module tb_dmem_arbiter_vliw;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 140001;
`ifdef DMEM_LOAD_MERGE_EN
    localparam bit MERGE_ON = 1'b1;
`else
    localparam bit MERGE_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          stall, rvalid0, rvalid1, oob, mem_en, mem_we, state_dbg;
    logic [DW-1:0] rdata0, rdata1, mem_di;
    logic [DW-1:0] mem_dout = '0;
    logic [AW-1:0] mem_addr;

    dmem_arbiter_vliw dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .stall(stall), .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .oob(oob), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_dout(mem_dout), .state_dbg(state_dbg)
    );

    // ---------------- read-first RAM model ----------------
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr[9:0]];
            if (mem_we) ram[mem_addr[9:0]] <= mem_di;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp0_q[$], exp1_q[$];
    int            cyc0_q[$], cyc1_q[$], oob_q[$];
    logic [DW-1:0] last0 = '0, last1 = '0;
    logic [DW-1:0] mon_e;
    int            mon_c;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid0) begin
                total++;
                if (exp0_q.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid0_unexpected: got data %h at cycle %0d", rdata0, cyc);
                end else begin
                    mon_e = exp0_q.pop_front();
                    mon_c = cyc0_q.pop_front();
                    if (rdata0 !== mon_e || cyc != mon_c) begin
                        bad++;
                        $display("FAIL rdata0: got %h at cycle %0d expected %h at cycle %0d", rdata0, cyc, mon_e, mon_c);
                    end
                end
            end
            if (rvalid1) begin
                total++;
                if (exp1_q.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid1_unexpected: got data %h at cycle %0d", rdata1, cyc);
                end else begin
                    mon_e = exp1_q.pop_front();
                    mon_c = cyc1_q.pop_front();
                    if (rdata1 !== mon_e || cyc != mon_c) begin
                        bad++;
                        $display("FAIL rdata1: got %h at cycle %0d expected %h at cycle %0d", rdata1, cyc, mon_e, mon_c);
                    end
                end
            end
            if (oob) begin
                total++;
                if (oob_q.size() == 0) begin
                    bad++;
                    $display("FAIL oob_unexpected: got 1 at cycle %0d expected 0", cyc);
                end else begin
                    mon_c = oob_q.pop_front();
                    if (cyc != mon_c) begin
                        bad++;
                        $display("FAIL oob_cycle: got cycle %0d expected cycle %0d", cyc, mon_c);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one bundle, checks the memory-side issue sequence, pushes the
    // expected results, then checks that rdata holds one cycle later.
    task automatic run_bundle(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        logic o0, o1, mrg, dual, fo;
        int   t;
        o0   = (int'(a0) >= DEPTH);
        o1   = (int'(a1) >= DEPTH);
        mrg  = MERGE_ON && v0 && v1 && !we0 && !we1 && (a0 == a1) && !o0;
        dual = v0 && v1 && !mrg;
        @(posedge clk); #1;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        check("stall_first", stall, dual);
        if (v0 || v1) begin
            fo = v0 ? o0 : o1;
            check("mem_en_first", mem_en, !fo);
            if (!fo) begin
                check("mem_addr_first", mem_addr, v0 ? a0 : a1);
                check("mem_we_first", mem_we, v0 ? we0 : we1);
            end
        end else begin
            check("mem_en_idle", mem_en, 1'b0);
        end
        if (dual) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_second", stall, 1'b0);
            check("mem_en_second", mem_en, !o1);
            if (!o1) begin
                check("mem_addr_second", mem_addr, a1);
                check("mem_we_second", mem_we, we1);
            end
        end
        t = cyc;
        if (v0 && !we0) begin exp0_q.push_back(e0); cyc0_q.push_back(t + 1); last0 = e0; end
        if (v1 && !we1) begin exp1_q.push_back(e1); cyc1_q.push_back(t + 1); last1 = e1; end
        if ((v0 && o0) || (v1 && o1)) oob_q.push_back(t + 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("rdata0_hold", rdata0, last0);
        check("rdata1_hold", rdata1, last1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[5] = 32'hDEADBEEF;
        ram[3] = 32'h0000000A;
        ram[4] = 32'h0000000B;
        ram[7] = 32'h00000055;

        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_state", state_dbg, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_rdata0", rdata0, '0);
        check("rst_rdata1", rdata1, '0);
        check("rst_oob", oob, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        rst = 1'b0;

        // single lane-0 load
        run_bundle(1, 0, 18'd5, 32'h0, 0, 0, 18'd0, 32'h0, 32'hDEADBEEF, 32'h0);
        // lane0 store + lane1 load same address: lane 1 sees new value
        run_bundle(1, 1, 18'd10, 32'h11, 1, 0, 18'd10, 32'h0, 32'h0, 32'h11);
        // dual loads
        run_bundle(1, 0, 18'd3, 32'h0, 1, 0, 18'd4, 32'h0, 32'hA, 32'hB);
        // lane-1 out-of-range load
        run_bundle(0, 0, 18'd0, 32'h0, 1, 0, 18'd140001, 32'h0, 32'h0, 32'h0);
        // lane0 load + lane1 store same address: lane 0 sees old value
        run_bundle(1, 0, 18'd3, 32'h0, 1, 1, 18'd3, 32'h99, 32'hA, 32'h0);
        run_bundle(1, 0, 18'd3, 32'h0, 0, 0, 18'd0, 32'h0, 32'h99, 32'h0);
        // two stores to the same address: lane 1 persists
        run_bundle(1, 1, 18'd20, 32'h1, 1, 1, 18'd20, 32'h2, 32'h0, 32'h0);
        run_bundle(0, 0, 18'd0, 32'h0, 1, 0, 18'd20, 32'h0, 32'h0, 32'h2);
        // same-address dual loads (merged only when the macro is defined)
        run_bundle(1, 0, 18'd7, 32'h0, 1, 0, 18'd7, 32'h0, 32'h55, 32'h55);
        // invalid request with other fields set is ignored
        run_bundle(0, 1, 18'd5, 32'h12345678, 0, 1, 18'd5, 32'h9, 32'h0, 32'h0);
        run_bundle(1, 0, 18'd5, 32'h0, 0, 0, 18'd0, 32'h0, 32'hDEADBEEF, 32'h0);
        // lane-0 out-of-range inside a dual bundle
        run_bundle(1, 0, 18'd200000, 32'h0, 1, 0, 18'd4, 32'h0, 32'h0, 32'hB);

        // reset during SECOND aborts the bundle
        @(posedge clk); #1;
        req0_valid = 1; req0_we = 0; req0_addr = 18'd3;
        req1_valid = 1; req1_we = 0; req1_addr = 18'd4;
        @(negedge clk);
        check("rst_mid_stall_pre", stall, 1'b1);
        @(posedge clk); #1;
        check("rst_mid_state_pre", state_dbg, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_state", state_dbg, 1'b0);
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_mem_en", mem_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        check("rst_mid_rvalid0", rvalid0, 1'b0);
        check("rst_mid_rvalid1", rvalid1, 1'b0);

        repeat (3) @(negedge clk);
        check("exp0_q_drained", 32'(exp0_q.size()), 32'd0);
        check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);
        check("oob_q_drained", 32'(oob_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout at cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter_vliw.md
Name: dmem_arbiter_vliw

Overview:
- Shares the single-port, read-first, 1-cycle-latency data memory between the two load/store slots of a VLIW bundle.
- Serialises dual-slot bundles over two cycles, with lane 0 before lane 1 (program order).
- Raises stall to freeze the pipeline during serialisation.
- Returns per-lane load data aligned to the cycle after bundle acceptance.

Parameters:
- ADDR_W, 18, word-address width presented to memory.
- DATA_W, 32, data word width.
- DEPTH, 140001, number of valid words; addresses >= DEPTH are out of range.

Ports:
- clk  input  1  single clock, posedge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  lane 0 / lane 1 memory op present in current bundle.
- req0_we / req1_we  input  1  1 = store, 0 = load.
- req0_addr / req1_addr  input  ADDR_W  word address.
- req0_wdata / req1_wdata  input  DATA_W  store data.
- stall  output  1  bundle not accepted this cycle; pipeline holds all req* stable.
- rdata0 / rdata1  output  DATA_W  load result per lane.
- rvalid0 / rvalid1  output  1  load result valid this cycle (one-cycle pulse).
- oob  output  1  pulse: an accepted op addressed >= DEPTH.
- mem_en, mem_we  output  1  to RAM.
- mem_addr  output  ADDR_W  to RAM.
- mem_di  output  DATA_W  to RAM.
- mem_dout  input  DATA_W  from RAM, valid the cycle after mem_en.

Behaviour:
- Reset values: state=IDLE, stall=0, rvalid0/1=0, rdata0/1=0, oob=0, mem_en=0, mem_we=0. Reset asserted mid-bundle aborts the second access; any pending rvalid is dropped.
- FSM states: IDLE, SECOND.
- IDLE, no valid request: mem_en=0, stall=0.
- IDLE, exactly one lane valid: issue that lane combinationally (mem_en=1, mem_we/addr/di from that lane), stall=0. The bundle is accepted this cycle (T).
- IDLE, both lanes valid: issue lane 0, stall=1, next state SECOND.
- SECOND: issue lane 1, stall=0, next state IDLE. The bundle is accepted this cycle (T). Lane-0 load data (mem_dout) is captured into a holding register this cycle.
- Result timing: at T+1, rvalid pulses for each lane that was a load. rdataN is mem_dout for the last-issued lane and the holding register for a lane-0 load issued in a dual bundle. rdata holds its value until the next load result.
- Stores never assert rvalid.
- Same-address ordering follows from lane-0-first issue and read-first RAM:
  - lane0 store + lane1 load: lane 1 sees the new value.
  - lane0 load + lane1 store: lane 0 sees the old value.
  - two stores: lane 1 data persists.
- Out of range (addr >= DEPTH): that access is suppressed (mem_en=0 for it). A load returns 0 with rvalid still pulsed at the normal cycle. oob pulses at T+1.
- A request with valid=0 is ignored regardless of the other fields.
- Input stability while stall=1 is a pipeline obligation. The arbiter re-samples lane 1 in SECOND and does not latch it.

Optional Feature:
- Macro: DMEM_LOAD_MERGE_EN.
- Defined: both lanes are loads to the same in-range address. A single access is issued from IDLE with stall=0, and both rvalids pulse at T+1 with identical rdata.
- Undefined: this case is serialised like any dual bundle (1 stall cycle).

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, SECOND};
  - DATA_W and ADDR_W defaults;
  - DEPTH constant;
  - lane-select constants.
- No sub-module: a single FSM plus a capture register fits in one module.

Test Plan:
- Single lane-0 load of addr 5, RAM[5]=0xDEADBEEF -> stall=0; mem_en=1 addr=5 at T; rvalid0=1 rdata0=0xDEADBEEF at T+1; rvalid1=0.
- Dual bundle: lane0 store addr 10 data 0x11, lane1 load addr 10 -> stall=1 for one cycle; second cycle mem_addr=10 we=0; rdata1=0x11 at T+1.
- Dual loads from addrs 3 and 4, RAM[3]=0xA and RAM[4]=0xB -> one stall cycle; at T+1 rdata0=0xA, rdata1=0xB, both rvalid=1.
- Lane-1 load at addr 140001 -> no mem_en; rdata1=0, rvalid1=1, oob=1 at T+1.
- rst asserted in SECOND -> state IDLE, stall=0, mem_en=0 immediately; no rvalid at next cycle.
- With DMEM_LOAD_MERGE_EN, dual loads at addr 7 (RAM[7]=0x55) -> stall never 1, one access; rdata0=rdata1=0x55 at T+1. Without the macro -> one stall cycle, same data.
